// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// seg_pkg : shared types, segment table and index helpers for the scan block
// Revision : 1.0
// ============================================================================
package seg_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Entry n is the pattern for code n; bit 0 = a ... bit 6 = g.
    localparam logic [7:0][8:0] SEG_PATTERNS = {
        9'h007, 9'h07d, 9'h06d, 9'h066, 9'h04f, 9'h05b, 9'h006, 9'h03f
    };

    localparam logic [8:0] SEG_BLANK = 9'h000;
    localparam logic [7:0] CAT_NONE  = 8'hFF;

    function automatic logic [7:0] cat_select(input logic [2:0] idx);
        return ~(8'h01 << idx);
    endfunction

    // First enabled digit after cur, circularly; cur itself is the last candidate.
    function automatic logic [2:0] next_enabled(input logic [2:0] cur, input logic [7:0] en);
        logic [2:0] cand;
        logic [2:0] res;
        res = cur;
        for (int k = 8; k >= 1; k--) begin
            cand = cur + 3'(k);
            if (en[cand]) res = cand;
        end
        return res;
    endfunction

    function automatic logic [2:0] lowest_enabled(input logic [7:0] en);
        logic [2:0] res;
        res = '0;
        for (int k = 7; k >= 0; k--) begin
            if (en[k]) res = 3'(k);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_lut.sv
`default_nettype none
// ============================================================================
// seg_lut3 : combinational 3-bit code to 9-bit segment pattern lookup
// Revision : 1.0
// ============================================================================
module seg_lut3
    import seg_pkg::*;
(
    input  logic [2:0] i_code,
    output logic [8:0] o_seg
);

    assign o_seg = SEG_PATTERNS[i_code];

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// seg_scan_ctrl : 8-digit seven-segment scan controller with frame-atomic
//                 shadow/active digit banks
// Revision : 1.0
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV          = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [2:0] wr_data,
    input  logic [7:0] digit_en,
    output logic [8:0] seg,
    output logic [7:0] cat,
    output logic       frame_done
);

    localparam int MAX_CYC = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t                       r_state;
    logic [2:0]                   r_idx;
    logic [CNT_W-1:0]             r_cnt;
    logic [NUM_DIGITS-1:0][2:0]   r_shadow;
    logic [NUM_DIGITS-1:0][2:0]   r_active;

    logic [8:0] w_lut_seg;
    logic [2:0] w_next_idx;
    logic       w_en_any;

    assign w_en_any   = |digit_en;
    assign w_next_idx = next_enabled(r_idx, digit_en);

    seg_lut3 u_lut (
        .i_code (r_active[r_idx]),
        .o_seg  (w_lut_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BLANK;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_active   <= '0;
            cat        <= CAT_NONE;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // The commit below samples the pre-write shadow, so a same-cycle write waits a frame.
            if (wr_en) r_shadow[wr_addr] <= wr_data;

            case (r_state)
                ST_OFF: begin
                    r_active <= r_shadow;
                    r_cnt    <= '0;
                    cat      <= CAT_NONE;
                    seg      <= SEG_BLANK;
                    if (w_en_any) begin
                        r_state <= ST_BLANK;
                        r_idx   <= lowest_enabled(digit_en);
                    end
                end
                ST_BLANK: begin
                    if (!w_en_any) begin
                        r_state <= ST_OFF;
                        r_cnt   <= '0;
                    end else if (r_cnt == BLANK_LAST) begin
                        r_state <= ST_SHOW;
                        r_cnt   <= '0;
                        cat     <= cat_select(r_idx);
                        seg     <= w_lut_seg;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        r_cnt <= '0;
                        cat   <= CAT_NONE;
                        seg   <= SEG_BLANK;
                        if (!w_en_any) begin
                            r_state <= ST_OFF;
                        end else begin
                            r_state <= ST_BLANK;
                            r_idx   <= w_next_idx;
                            if (w_next_idx <= r_idx) begin
                                frame_done <= 1'b1;
                                r_active   <= r_shadow;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_BLANK;
                    r_cnt   <= '0;
                    cat     <= CAT_NONE;
                    seg     <= SEG_BLANK;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for an 8-digit common-cathode seven-segment display. It holds one 3-bit code per digit and steps through the enabled digits at a fixed slot rate. For each digit it shows a blanking guard, then drives that digit's cathode low together with the decoded segment pattern, so one shared 3-bit-to-segment lookup serves all digits. It sits between the board's value sources (counters, FSM state displays) and the segment/cathode pins.

## Interface
- `NUM_DIGITS`, default 8: number of digits scanned. Fixed at 8 for this board, because the index is 3 bits wide.
- `DIV`, default 1000: clock cycles per digit in the SHOW state. Must be ≥ 1.
- `BLANK_CYCLES`, default 2: clock cycles per digit in the BLANK guard state. Must be ≥ 1.
- `clk`, input, 1: the single clock for the block.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `wr_en`, input, 1: writes `wr_data` into shadow entry `wr_addr`.
- `wr_addr`, input, 3: digit index to write.
- `wr_data`, input, 3: code for that digit.
- `digit_en`, input, 8: per-digit enable mask. A 0 bit means the digit is skipped.
- `seg`, output, 9: segment pattern, active-high; bit 0 = a … bit 6 = g, bits 8:7 = 0.
- `cat`, output, 8: digit cathodes, active-low; one-hot-low or all-high.
- `frame_done`, output, 1: one-cycle pulse when the scan wraps.

## Operation
- Storage has two banks of 8×3 bits, shadow and active.
  - `wr_en` writes the shadow bank only.
  - The active bank feeds the display.
- At every frame boundary, shadow is copied to active, so no frame ever shows a partial update.
- States:
  - OFF: entered when `digit_en` == 0. `cat`=8'hFF, `seg`=0. The shadow bank is copied to active every cycle.
  - BLANK: lasts `BLANK_CYCLES` cycles. `cat`=8'hFF, `seg`=0.
  - SHOW: lasts `DIV` cycles. `cat[idx]`=0 and all other bits are 1. `seg`=LUT(active[idx]).
- Transitions:
  - BLANK → SHOW when the cycle counter reaches `BLANK_CYCLES`-1.
  - SHOW → BLANK when the counter reaches `DIV`-1. At the same time, `idx` advances to the next enabled index, searching circularly from `idx`+1.
  - If the new `idx` ≤ old `idx` (wrap, including a single enabled digit), that edge is a frame boundary: `frame_done`=1 for that cycle and the bank commit happens.
  - Any state → OFF when `digit_en` == 0, sampled at each slot end and also in BLANK.
  - OFF → BLANK as soon as `digit_en` ≠ 0, with `idx` set to the lowest enabled digit.
- The LUT maps codes 0..7 to 9'h3f, 06, 5b, 4f, 66, 6d, 7d, 07.
- Boundary conditions:
  - A `digit_en` change mid-slot does not shorten the current slot. The new mask is used at the next advance.
  - A `wr_en` in the same cycle as a commit updates the shadow bank only. That value commits at the following boundary.
  - Repeated writes to one address within a frame: the last write wins.
  - The counter clears on every state change, so there is no overflow path.
- Reset mid-operation, at any cycle, returns every register to its reset value immediately, asynchronously.

## Timing
- Reset values:
  - state = BLANK, `idx`=0, counter=0.
  - Both banks = 0.
  - `cat`=8'hFF, `seg`=0, `frame_done`=0.
- `cat`, `seg` and `frame_done` are registered. They change on the same edge that enters the new state.
- The counter is $clog2(max(`DIV`,`BLANK_CYCLES`)) bits wide.
- Slot period = `BLANK_CYCLES`+`DIV`.
- Frame period = (number of enabled digits)×(`BLANK_CYCLES`+`DIV`) cycles.
- Write-to-display latency is at most one frame plus one slot. In OFF it is 1 cycle to the active bank.

## Structure
- Shared package `seg_pkg` holds:
  - the state enum (OFF, BLANK, SHOW);
  - the 8-entry segment pattern constant;
  - `SEG_BLANK`=9'h000 and `CAT_NONE`=8'hFF.
- Sub-module `seg_lut3` is the purely combinational 3-bit → 9-bit lookup. It is instantiated once and fed by `active[idx]`.
- The FSM, counter, next-enabled-index search and banks live in `seg_scan_ctrl`.

## Test plan
All scenarios use `DIV`=4, `BLANK_CYCLES`=1.

- **Reset, full scan:** Release reset with `digit_en`=8'hFF and all codes 0.
  - `cat` sequence: FF, FE×4, FF, FD×4, … FF, 7F×4.
  - `seg`=9'h03f whenever `cat`≠FF.
  - `frame_done` pulses every 40 cycles.
- **Frame commit:** Write addr 2 = 3'd5 mid-frame.
  - Digit 2 keeps showing 9'h03f until after the next `frame_done`, then shows 9'h06d.
  - A write in the `frame_done` cycle appears one frame later.
- **Skip mask:** `digit_en`=8'b1000_0010.
  - `cat` alternates FF, FD×4, FF, 7F×4.
  - `frame_done` pulses every 10 cycles.
  - Single enabled digit 8'h01: `frame_done` pulses every 5 cycles.
- **OFF:** Drop `digit_en` to 0 mid-SHOW.
  - The current slot finishes, then the block goes to OFF: `cat`=FF, `seg`=0.
  - A write in OFF is visible 1 cycle after re-enable plus the BLANK cycle.
- **Async reset:** Assert `rst_n`=0 mid-SHOW on digit 5.
  - `cat`=FF and `seg`=0 without waiting for a clock edge.
  - Both banks read 0 after release.
  - The scan restarts at digit 0 with BLANK.
